// File: rtl/alien_swarm.sv
// alien_swarm: invader grid, swarm march, laser collision and per-pixel sprite output.
// Game state advances once per frame on the rising edge of the synchronised vsync.
module alien_swarm #(
  parameter int COLS            = 8,
  parameter int ROWS            = 4,
  parameter int SPACING         = 32,
  parameter int ALIEN_W         = 24,
  parameter int ALIEN_H         = 16,
  parameter int START_X         = 64,
  parameter int START_Y         = 48,
  parameter int STEP_X          = 4,
  parameter int STEP_Y          = 16,
  parameter int FRAMES_PER_STEP = 30,
  parameter int LEFT_BOUND      = 16,
  parameter int RIGHT_BOUND     = 624,
  parameter int BOTTOM_LIMIT    = 420
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       reset_game,
  input  logic       laser_active,
  input  logic [9:0] laser_x,
  input  logic [9:0] laser_y,
  output logic       alien_gfx,
  output logic       hit_alien,
  output logic [5:0] score_add,
  output logic       wave_clear,
  output logic       invaded
);
  localparam int N  = COLS * ROWS;
  localparam int SH = $clog2(SPACING);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [10:0] GW   = 11'((COLS - 1) * SPACING + ALIEN_W);
  localparam logic [10:0] GH   = 11'((ROWS - 1) * SPACING + ALIEN_H);
  localparam logic [10:0] MASK = 11'(SPACING - 1);
  localparam logic [10:0] AW   = 11'(ALIEN_W);
  localparam logic [10:0] AH   = 11'(ALIEN_H);
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  logic [1:0]    vs_q, vs_d;
  logic [N-1:0]  alive_q, alive_d;
  logic [9:0]    sx_q, sx_d, sy_q, sy_d;
  logic          dir_q, dir_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic [5:0]    score_q, score_d;
  logic          invaded_q, invaded_d;

  logic          tick;
  logic [10:0]   ldx, ldy, lrow;
  logic          laser_hit;
  logic [5:0]    pts;

  function automatic logic [IW-1:0] cell_idx(input logic [10:0] dx, input logic [10:0] dy);
    cell_idx = IW'((dy >> SH) * 11'(COLS) + (dx >> SH));
  endfunction

  // Negative offsets show up as bit 10 set, so the unsigned range checks stay simple.
  function automatic logic inside_f(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] ox, input logic [9:0] oy,
                                    input logic [N-1:0] alv);
    logic [10:0] dx;
    logic [10:0] dy;
    dx = {1'b0, px} - {1'b0, ox};
    dy = {1'b0, py} - {1'b0, oy};
    if (!dx[10] && !dy[10] && dx < GW && dy < GH && (dx & MASK) < AW && (dy & MASK) < AH) begin
      inside_f = alv[cell_idx(dx, dy)];
    end else begin
      inside_f = 1'b0;
    end
  endfunction

  assign tick       = vs_q[0] & ~vs_q[1];
  assign ldx        = {1'b0, laser_x} - {1'b0, sx_q};
  assign ldy        = {1'b0, laser_y} - {1'b0, sy_q};
  assign lrow       = ldy >> SH;
  assign laser_hit  = laser_active && !invaded_q && inside_f(laser_x, laser_y, sx_q, sy_q, alive_q);
  assign wave_clear = (alive_q == {N{1'b0}});
  assign alien_gfx  = !invaded_q && inside_f(hpos, vpos, sx_q, sy_q, alive_q);
  assign hit_alien  = hit_q;
  assign score_add  = score_q;
  assign invaded    = invaded_q;

  always_comb begin
    case (lrow)
      11'd0:   pts = 6'd30;
      11'd1:   pts = 6'd20;
      default: pts = 6'd10;
    endcase
  end

  always_comb begin
    vs_d      = {vs_q[0], vsync};
    alive_d   = alive_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    score_d   = score_q;
    invaded_d = invaded_q;
    if (reset_game || (tick && wave_clear)) begin
      alive_d   = {N{1'b1}};
      sx_d      = 10'(START_X);
      sy_d      = 10'(START_Y);
      dir_d     = DIR_RIGHT;
      cnt_d     = {FW{1'b0}};
      hit_d     = 1'b0;
      score_d   = 6'd0;
      invaded_d = reset_game ? 1'b0 : invaded_q;
    end else if (tick) begin
      if (laser_hit) begin
        alive_d[cell_idx(ldx, ldy)] = 1'b0;
        hit_d   = 1'b1;
        score_d = pts;
      end else begin
        hit_d   = 1'b0;
        score_d = 6'd0;
      end
      if (invaded_q) begin
        cnt_d = cnt_q;
      end else if (cnt_q == FW'(FRAMES_PER_STEP - 1)) begin
        cnt_d = {FW{1'b0}};
        // An edge step only drops and reverses; the next step moves horizontally.
        if (dir_q == DIR_RIGHT) begin
          if ({1'b0, sx_q} + GW + 11'(STEP_X) > 11'(RIGHT_BOUND)) begin
            sy_d  = sy_q + 10'(STEP_Y);
            dir_d = DIR_LEFT;
          end else begin
            sx_d = sx_q + 10'(STEP_X);
          end
        end else begin
          if (sx_q < 10'(LEFT_BOUND + STEP_X)) begin
            sy_d  = sy_q + 10'(STEP_Y);
            dir_d = DIR_RIGHT;
          end else begin
            sx_d = sx_q - 10'(STEP_X);
          end
        end
        if ((alive_d != {N{1'b0}}) && (({1'b0, sy_d} + GH) >= 11'(BOTTOM_LIMIT))) begin
          invaded_d = 1'b1;
        end else begin
          invaded_d = invaded_q;
        end
      end else begin
        cnt_d = cnt_q + FW'(1);
      end
    end else begin
      hit_d = hit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 2'b00;
      alive_q   <= {N{1'b1}};
      sx_q      <= 10'(START_X);
      sy_q      <= 10'(START_Y);
      dir_q     <= DIR_RIGHT;
      cnt_q     <= {FW{1'b0}};
      hit_q     <= 1'b0;
      score_q   <= 6'd0;
      invaded_q <= 1'b0;
    end else begin
      vs_q      <= vs_d;
      alive_q   <= alive_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      score_q   <= score_d;
      invaded_q <= invaded_d;
    end
  end

endmodule

// File: tb/tb_alien_swarm.sv
// Bench for alien_swarm: default swarm (hits, scoring, wave clear), a march-edge swarm
// and an invasion swarm, each with its own vsync so they advance independently.
module tb_alien_swarm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos = 10'd0, vpos = 10'd0;
  logic       vs_a = 1'b0, vs_b = 1'b0, vs_c = 1'b0;
  logic       rg_c = 1'b0;
  logic       laser_active = 1'b0;
  logic [9:0] laser_x = 10'd0, laser_y = 10'd0;

  logic       gfx_a, hit_a, wc_a, inv_a;
  logic [5:0] score_a;
  logic       gfx_b, hit_b, wc_b, inv_b;
  logic [5:0] score_b;
  logic       gfx_c, hit_c, wc_c, inv_c;
  logic [5:0] score_c;

  int n_checks = 0;
  int n_errors = 0;
  int ticks_a  = 0;

  typedef struct {
    string      tag;
    logic       hit;
    logic [5:0] score;
  } exp_t;
  exp_t sb_q[$];
  bit   dead[4][8];

  always #5 clk = ~clk;

  alien_swarm u_a (
    .clk(clk), .rst_n(rst_n), .vsync(vs_a), .hpos(hpos), .vpos(vpos), .reset_game(1'b0),
    .laser_active(laser_active), .laser_x(laser_x), .laser_y(laser_y),
    .alien_gfx(gfx_a), .hit_alien(hit_a), .score_add(score_a), .wave_clear(wc_a), .invaded(inv_a)
  );

  alien_swarm #(.FRAMES_PER_STEP(1), .START_X(372)) u_b (
    .clk(clk), .rst_n(rst_n), .vsync(vs_b), .hpos(hpos), .vpos(vpos), .reset_game(1'b0),
    .laser_active(1'b0), .laser_x(10'd0), .laser_y(10'd0),
    .alien_gfx(gfx_b), .hit_alien(hit_b), .score_add(score_b), .wave_clear(wc_b), .invaded(inv_b)
  );

  alien_swarm #(.FRAMES_PER_STEP(1), .START_Y(308)) u_c (
    .clk(clk), .rst_n(rst_n), .vsync(vs_c), .hpos(hpos), .vpos(vpos), .reset_game(rg_c),
    .laser_active(1'b0), .laser_x(10'd0), .laser_y(10'd0),
    .alien_gfx(gfx_c), .hit_alien(hit_c), .score_add(score_c), .wave_clear(wc_c), .invaded(inv_c)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic look(input int x, input int y);
    hpos = 10'(x);
    vpos = 10'(y);
    #1;
  endtask

  // One frame: vsync high then low; the tick lands two clocks after the rise.
  task automatic frame(input int which);
    @(negedge clk);
    case (which)
      0: vs_a = 1'b1;
      1: vs_b = 1'b1;
      default: vs_c = 1'b1;
    endcase
    repeat (3) @(negedge clk);
    vs_a = 1'b0; vs_b = 1'b0; vs_c = 1'b0;
    repeat (3) @(negedge clk);
    if (which == 0) ticks_a++;
  endtask

  task automatic shoot(input string tag, input int x, input int y, input logic eh, input logic [5:0] es);
    exp_t e;
    laser_active = 1'b1;
    laser_x = 10'(x);
    laser_y = 10'(y);
    sb_q.push_back('{tag, eh, es});
    frame(0);
    laser_active = 1'b0;
    e = sb_q.pop_front();
    check({e.tag, "_hit"}, int'(hit_a), int'(e.hit));
    check({e.tag, "_score"}, int'(score_a), int'(e.score));
  endtask

  function automatic logic [5:0] row_pts(input int r);
    return (r == 0) ? 6'd30 : (r == 1) ? 6'd20 : 6'd10;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int sxm;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hit", int'(hit_a), 0);
    check("rst_score", int'(score_a), 0);
    check("rst_wave_clear", int'(wc_a), 0);
    check("rst_invaded", int'(inv_a), 0);

    // default swarm: three quiet frames leave the origin at (64,48)
    repeat (3) frame(0);
    look(64, 48);  check("gfx_origin", int'(gfx_a), 1);
    look(63, 48);  check("gfx_left_of_origin", int'(gfx_a), 0);
    look(88, 48);  check("gfx_col_gap", int'(gfx_a), 0);
    look(64, 64);  check("gfx_row_gap", int'(gfx_a), 0);

    shoot("hit_r0c0", 69, 51, 1'b1, 6'd30);
    repeat (10) @(negedge clk);
    check("hit_held_mid_frame", int'(hit_a), 1);
    dead[0][0] = 1'b1;
    look(69, 51);  check("gfx_after_kill", int'(gfx_a), 0);
    shoot("rehit_dead", 69, 51, 1'b0, 6'd0);
    shoot("gap_miss", 90, 51, 1'b0, 6'd0);
    shoot("hit_r1c1", 101, 85, 1'b1, 6'd20);
    dead[1][1] = 1'b1;
    shoot("hit_r2c0", 69, 115, 1'b1, 6'd10);
    dead[2][0] = 1'b1;
    shoot("hit_r3c0", 69, 147, 1'b1, 6'd10);
    dead[3][0] = 1'b1;

    // clear the rest of the wave; origin x advances 4 px every 30 frames
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (!dead[r][c]) begin
          check("wave_not_clear_yet", int'(wc_a), 0);
          sxm = 64 + 4 * (ticks_a / 30);
          shoot($sformatf("kill_r%0dc%0d", r, c), sxm + c * 32 + 2, 48 + r * 32 + 2, 1'b1, row_pts(r));
          dead[r][c] = 1'b1;
        end
      end
    end
    check("wave_clear_set", int'(wc_a), 1);
    frame(0);
    check("respawn_wave_clear", int'(wc_a), 0);
    check("respawn_hit", int'(hit_a), 0);
    check("respawn_score", int'(score_a), 0);
    look(64, 48);   check("respawn_origin", int'(gfx_a), 1);
    look(63, 48);   check("respawn_left", int'(gfx_a), 0);
    look(64, 47);   check("respawn_above", int'(gfx_a), 0);
    look(290, 146); check("respawn_last_cell", int'(gfx_a), 1);

    // march edge swarm: 372 -> 376 -> drop to y=64 -> 372
    look(372, 48); check("march0_origin", int'(gfx_b), 1);
    look(371, 48); check("march0_left", int'(gfx_b), 0);
    frame(1);
    look(376, 48); check("march1_origin", int'(gfx_b), 1);
    look(375, 48); check("march1_left", int'(gfx_b), 0);
    frame(1);
    look(376, 64); check("march2_origin", int'(gfx_b), 1);
    look(376, 63); check("march2_above", int'(gfx_b), 0);
    look(375, 64); check("march2_left", int'(gfx_b), 0);
    frame(1);
    look(372, 64); check("march3_origin", int'(gfx_b), 1);
    look(371, 64); check("march3_left", int'(gfx_b), 0);
    check("march_not_invaded", int'(inv_b), 0);

    // invasion swarm: sy+GH = 420 reaches the limit on the first step
    check("inv_reset", int'(inv_c), 0);
    look(64, 308); check("inv_gfx_before", int'(gfx_c), 1);
    frame(2);
    check("inv_set", int'(inv_c), 1);
    look(68, 308); check("inv_gfx_forced_off", int'(gfx_c), 0);
    frame(2);
    check("inv_sticky", int'(inv_c), 1);
    @(negedge clk);
    rg_c = 1'b1;
    @(negedge clk);
    rg_c = 1'b0;
    check("rg_invaded_clear", int'(inv_c), 0);
    look(64, 308); check("rg_origin", int'(gfx_c), 1);
    look(63, 308); check("rg_left", int'(gfx_c), 0);
    // reset_game held across a tick wins over the march step
    @(negedge clk);
    vs_c = 1'b1; rg_c = 1'b1;
    repeat (4) @(negedge clk);
    vs_c = 1'b0; rg_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rg_over_tick_inv", int'(inv_c), 0);
    look(64, 308); check("rg_over_tick_origin", int'(gfx_c), 1);
    look(63, 308); check("rg_over_tick_left", int'(gfx_c), 0);
    frame(2);
    check("inv_again", int'(inv_c), 1);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
